// File: rtl/adv_i2c_config_sequencer.sv
// Feeds the 24-bit I2C write master one {slave,reg,data} word at a time from the
// fixed HDMI transmitter register table, with per-entry retry and hot-plug restart.
//
// state    | meaning
// STARTUP  | power-up delay after reset
// WAIT_HPD | idle until the sink is plugged in
// LOAD     | latch current table entry onto i2cData
// GO       | raise i2cGo, clear watchdog
// WAIT     | hold i2cGo until i2cDone or watchdog expiry
// NEXT     | advance to the next entry or finish
// RETRY    | count the failed attempt, give up after MAX_RETRIES
// BACKOFF  | pause RETRY_CYCLES before re-sending the same entry
// DONE     | whole table written successfully
// FAIL     | an entry exhausted its retries
module adv_i2c_config_sequencer #(
  parameter logic [7:0] SLAVE_ADDR     = 8'h72,
  parameter int         STARTUP_CYCLES = 1_000_000,
  parameter int         RETRY_CYCLES   = 50_000,
  parameter int         MAX_RETRIES    = 3,
  parameter int         TIMEOUT_CYCLES = 100_000
) (
  input  logic        refClock,
  input  logic        reset,
  input  logic        hpd,
  input  logic        start,
  output logic [23:0] i2cData,
  output logic        i2cGo,
  input  logic        i2cDone,
  input  logic        i2cAckErr,
  output logic [3:0]  regIndex,
  output logic        busy,
  output logic        configDone,
  output logic        configError
);

  localparam int NUM_REGS = 12;
  localparam int SU_W     = $clog2(STARTUP_CYCLES + 1);
  localparam int BO_W     = $clog2(RETRY_CYCLES + 1);
  localparam int WD_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RT_W     = $clog2(MAX_RETRIES + 1);

  typedef enum logic [3:0] {
    STARTUP,
    WAIT_HPD,
    LOAD,
    GO,
    WAIT,
    NEXT,
    RETRY,
    BACKOFF,
    DONE,
    FAIL
  } stateType;

  stateType        state;
  stateType        nextState;
  logic            hpdMeta;
  logic            hpdS;
  logic            hpdSDly;
  logic            hpdRise;
  logic            restart;
  logic            lastEntry;
  logic [15:0]     tableWord;
  logic [SU_W-1:0] startupCnt;
  logic [BO_W-1:0] backoffCnt;
  logic [WD_W-1:0] watchdogCnt;
  logic [RT_W-1:0] retryCnt;

  assign hpdRise   = hpdS & ~hpdSDly;
  assign restart   = hpdRise | start;
  assign lastEntry = (regIndex == 4'(NUM_REGS - 1));
  assign i2cGo     = (state == GO) || (state == WAIT);

  always_comb begin
    case (regIndex)
      4'd0:    tableWord = 16'h4110;
      4'd1:    tableWord = 16'h9803;
      4'd2:    tableWord = 16'h9AE0;
      4'd3:    tableWord = 16'h9C30;
      4'd4:    tableWord = 16'h9D61;
      4'd5:    tableWord = 16'hA2A4;
      4'd6:    tableWord = 16'hA3A4;
      4'd7:    tableWord = 16'hE0D0;
      4'd8:    tableWord = 16'hF900;
      4'd9:    tableWord = 16'h1500;
      4'd10:   tableWord = 16'h1630;
      4'd11:   tableWord = 16'h1846;
      default: tableWord = 16'h0000;
    endcase
  end

  always_ff @(posedge refClock or posedge reset) begin
    if (reset) begin
      state <= STARTUP;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      STARTUP: begin
        if (startupCnt == SU_W'(STARTUP_CYCLES - 1)) nextState = WAIT_HPD;
      end
      WAIT_HPD: begin
        if (hpdS) nextState = LOAD;
      end
      LOAD: begin
        nextState = hpdS ? GO : WAIT_HPD;
      end
      GO: begin
        nextState = hpdS ? WAIT : WAIT_HPD;
      end
      WAIT: begin
        // An in-flight write is never abandoned on HPD loss; i2cDone wins over expiry.
        if (i2cDone) begin
          if (!hpdS)          nextState = WAIT_HPD;
          else if (i2cAckErr) nextState = RETRY;
          else                nextState = NEXT;
        end else if (watchdogCnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
          nextState = hpdS ? RETRY : WAIT_HPD;
        end
      end
      NEXT: begin
        nextState = lastEntry ? DONE : LOAD;
      end
      RETRY: begin
        if (!hpdS)                              nextState = WAIT_HPD;
        else if (retryCnt == RT_W'(MAX_RETRIES)) nextState = FAIL;
        else                                    nextState = BACKOFF;
      end
      BACKOFF: begin
        if (!hpdS)                                        nextState = WAIT_HPD;
        else if (backoffCnt == BO_W'(RETRY_CYCLES - 1)) nextState = LOAD;
      end
      DONE: begin
        if (!hpdS)        nextState = WAIT_HPD;
        else if (restart) nextState = LOAD;
      end
      FAIL: begin
        if (restart) nextState = LOAD;
      end
      default: nextState = STARTUP;
    endcase
  end

  always_ff @(posedge refClock or posedge reset) begin
    if (reset) begin
      hpdMeta     <= 1'b0;
      hpdS        <= 1'b0;
      hpdSDly     <= 1'b0;
      i2cData     <= '0;
      regIndex    <= '0;
      busy        <= 1'b0;
      configDone  <= 1'b0;
      configError <= 1'b0;
      startupCnt  <= '0;
      backoffCnt  <= '0;
      watchdogCnt <= '0;
      retryCnt    <= '0;
    end else begin
      hpdMeta <= hpd;
      hpdS    <= hpdMeta;
      hpdSDly <= hpdS;

      case (state)
        STARTUP: startupCnt <= startupCnt + SU_W'(1);
        WAIT_HPD, DONE, FAIL: begin
          if (nextState == LOAD) begin
            regIndex    <= '0;
            retryCnt    <= '0;
            busy        <= 1'b1;
            configDone  <= 1'b0;
            configError <= 1'b0;
          end
        end
        LOAD: i2cData <= {SLAVE_ADDR, tableWord};
        GO:   watchdogCnt <= '0;
        WAIT: watchdogCnt <= watchdogCnt + WD_W'(1);
        NEXT: begin
          if (!lastEntry) begin
            regIndex <= regIndex + 4'd1;
            retryCnt <= '0;
          end
        end
        RETRY: begin
          backoffCnt <= '0;
          if (nextState == BACKOFF) retryCnt <= retryCnt + RT_W'(1);
        end
        BACKOFF: backoffCnt <= backoffCnt + BO_W'(1);
        default: ;
      endcase

      if ((nextState == WAIT_HPD) && (state != STARTUP) && (state != WAIT_HPD)) begin
        busy       <= 1'b0;
        configDone <= 1'b0;
      end
      if ((state == NEXT) && (nextState == DONE)) begin
        configDone <= 1'b1;
        busy       <= 1'b0;
      end
      if ((state == RETRY) && (nextState == FAIL)) begin
        configError <= 1'b1;
        busy        <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adv_i2c_config_sequencer.sv
// Directed bench for adv_i2c_config_sequencer: a behavioural I2C master acks each
// write ACK_DELAY cycles after a fresh i2cGo, with optional NACK or silence per entry.
`timescale 1ns/1ps
module tb_adv_i2c_config_sequencer;

  localparam int RETRY_CYC   = 20;
  localparam int TIMEOUT_CYC = 200;
  localparam int ACK_DELAY   = 30;

  logic        refClock = 1'b0;
  logic        reset = 1'b1;
  logic        hpd = 1'b0;
  logic        start = 1'b0;
  logic        i2cDone = 1'b0;
  logic        i2cAckErr = 1'b0;
  logic [23:0] i2cData;
  logic        i2cGo;
  logic [3:0]  regIndex;
  logic        busy;
  logic        configDone;
  logic        configError;

  adv_i2c_config_sequencer #(
    .STARTUP_CYCLES(100),
    .RETRY_CYCLES(RETRY_CYC),
    .TIMEOUT_CYCLES(TIMEOUT_CYC)
  ) dut (
    .refClock(refClock),
    .reset(reset),
    .hpd(hpd),
    .start(start),
    .i2cData(i2cData),
    .i2cGo(i2cGo),
    .i2cDone(i2cDone),
    .i2cAckErr(i2cAckErr),
    .regIndex(regIndex),
    .busy(busy),
    .configDone(configDone),
    .configError(configError)
  );

  always #5 refClock = ~refClock;

  typedef struct {
    logic [3:0]  idx;
    logic [23:0] data;
  } vecT;
  vecT vecs [12];

  int cyc = 0;
  always @(posedge refClock) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int relCyc = 0;

  // master model state and transaction log
  logic [23:0] txData [$];
  int          txIdx  [$];
  int          txRise [$];
  int          txHigh [$];
  int          nackCnt [12];
  bit          silent = 1'b0;
  int          stableErr = 0;
  bit          goPrev = 1'b0;
  bit          pend = 1'b0;
  int          dly = 0;
  int          pendIdx = 0;
  int          riseCyc = 0;
  logic [23:0] holdData = '0;

  initial begin
    forever begin
      @(negedge refClock);
      i2cDone   = 1'b0;
      i2cAckErr = 1'b0;
      if (reset) begin
        pend   = 1'b0;
        goPrev = 1'b0;
      end else begin
        if (pend) begin
          dly--;
          if (dly == 0) begin
            pend    = 1'b0;
            i2cDone = 1'b1;
            if (nackCnt[pendIdx] > 0) begin
              i2cAckErr = 1'b1;
              nackCnt[pendIdx]--;
            end
          end
        end
        if (i2cGo && !goPrev) begin
          txData.push_back(i2cData);
          txIdx.push_back(int'(regIndex));
          txRise.push_back(cyc);
          riseCyc  = cyc;
          holdData = i2cData;
          if (!silent) begin
            pend    = 1'b1;
            dly     = ACK_DELAY;
            pendIdx = int'(regIndex);
          end
        end
        if (!i2cGo && goPrev) txHigh.push_back(cyc - riseCyc);
        if (i2cGo && goPrev && (i2cData !== holdData)) stableErr++;
        goPrev = i2cGo;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL globalTimeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chkRange(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic waitFin(input string name, input int limit);
    int n = 0;
    while (!(configDone || configError) && n < limit) begin
      @(negedge refClock);
      n++;
    end
    chkRange({name, "Finish"}, n, 0, limit - 1);
  endtask

  task automatic waitTx(input string name, input int count, input int limit);
    int n = 0;
    while (txData.size() < count && n < limit) begin
      @(negedge refClock);
      n++;
    end
    chkRange({name, "TxArrive"}, n, 0, limit - 1);
  endtask

  task automatic pulseStart();
    @(negedge refClock);
    start = 1'b1;
    @(negedge refClock);
    start = 1'b0;
  endtask

  task automatic doReset(input logic hpdVal);
    @(negedge refClock);
    reset  = 1'b1;
    hpd    = hpdVal;
    start  = 1'b0;
    silent = 1'b0;
    foreach (nackCnt[i]) nackCnt[i] = 0;
    repeat (2) @(negedge refClock);
    txData.delete();
    txIdx.delete();
    txRise.delete();
    txHigh.delete();
    chk("resetOutputs", {i2cData, i2cGo, regIndex, busy, configDone, configError}, 32'h0);
    reset  = 1'b0;
    relCyc = cyc;
  endtask

  initial begin
    int base;
    int n;
    vecs[0]  = '{4'd0,  24'h724110};
    vecs[1]  = '{4'd1,  24'h729803};
    vecs[2]  = '{4'd2,  24'h729AE0};
    vecs[3]  = '{4'd3,  24'h729C30};
    vecs[4]  = '{4'd4,  24'h729D61};
    vecs[5]  = '{4'd5,  24'h72A2A4};
    vecs[6]  = '{4'd6,  24'h72A3A4};
    vecs[7]  = '{4'd7,  24'h72E0D0};
    vecs[8]  = '{4'd8,  24'h72F900};
    vecs[9]  = '{4'd9,  24'h721500};
    vecs[10] = '{4'd10, 24'h721630};
    vecs[11] = '{4'd11, 24'h721846};

    // full table with hpd present; a start pulse mid-run must be ignored
    doReset(1'b1);
    waitTx("t1", 4, 1000);
    pulseStart();
    waitFin("t1", 2000);
    chkRange("t1FirstGo", txRise[0] - relCyc, 100, 105);
    chk("t1TxCount", txData.size(), 12);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("t1Data%0d", i), txData[i], vecs[i].data);
      chk($sformatf("t1Idx%0d", i), txIdx[i], vecs[i].idx);
    end
    chk("t1DoneBusyErr", {configDone, busy, configError}, 3'b100);

    // no hpd: nothing happens until it arrives
    doReset(1'b0);
    repeat (500) @(negedge refClock);
    chk("t2NoGo", txData.size(), 0);
    chk("t2Idle", {busy, configDone, configError}, 3'b000);
    hpd = 1'b1;
    n = 0;
    while (!busy && n < 10) begin
      @(negedge refClock);
      n++;
    end
    chkRange("t2SyncLatency", n, 2, 3);
    waitFin("t2", 2000);
    chk("t2TxCount", txData.size(), 12);
    chk("t2Done", configDone, 1'b1);

    // single NACK on entry 3
    doReset(1'b1);
    nackCnt[3] = 1;
    waitFin("t3", 2000);
    chk("t3TxCount", txData.size(), 13);
    chk("t3FirstTry", txData[3], 24'h729C30);
    chk("t3Retry", txData[4], 24'h729C30);
    chk("t3RetryIdx", txIdx[4], 3);
    chk("t3BackoffGap", (txRise[4] - txRise[3]) - (txRise[3] - txRise[2]), RETRY_CYC);
    chk("t3Last", txData[12], 24'h721846);
    chk("t3DoneBusyErr", {configDone, busy, configError}, 3'b100);

    // entry 5 NACKed every time: 4 attempts then error, start re-runs
    doReset(1'b1);
    nackCnt[5] = 10;
    waitFin("t4", 3000);
    n = 0;
    foreach (txIdx[i]) if (txIdx[i] == 5) n++;
    chk("t4Attempts", n, 4);
    chk("t4TxCount", txData.size(), 9);
    chk("t4DoneBusyErr", {configDone, busy, configError}, 3'b001);
    repeat (100) @(negedge refClock);
    chk("t4QuietAfterFail", txData.size(), 9);
    nackCnt[5] = 0;
    pulseStart();
    chk("t4RestartFlags", {busy, configError}, 2'b10);
    waitFin("t4b", 2000);
    chk("t4RerunFirst", txData[9], 24'h724110);
    chk("t4RerunCount", txData.size(), 21);
    chk("t4RerunDone", {configDone, configError}, 2'b10);

    // silent master: watchdog expiry on every attempt
    doReset(1'b1);
    silent = 1'b1;
    waitFin("t5", 3000);
    chk("t5TxCount", txData.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t5Idx%0d", i), txIdx[i], 0);
      chkRange($sformatf("t5GoHigh%0d", i), txHigh[i], TIMEOUT_CYC, TIMEOUT_CYC + 2);
    end
    for (int i = 0; i < 3; i++)
      chkRange($sformatf("t5GoLow%0d", i), txRise[i + 1] - txRise[i] - txHigh[i], RETRY_CYC, RETRY_CYC + 5);
    chk("t5DoneErr", {configDone, configError}, 2'b01);

    // replug after DONE, then HPD loss while a write is in flight
    doReset(1'b1);
    waitFin("t6", 2000);
    chk("t6Done", configDone, 1'b1);
    hpd = 1'b0;
    repeat (10) @(negedge refClock);
    chk("t6HpdLossClears", {configDone, busy}, 2'b00);
    base = txData.size();
    hpd = 1'b1;
    repeat (3) @(negedge refClock);
    waitFin("t6b", 2000);
    chk("t6ReplugCount", txData.size(), base + 12);
    chk("t6ReplugFirst", txData[base], 24'h724110);
    chk("t6ReplugLast", txData[base + 11], 24'h721846);

    base = txData.size();
    pulseStart();
    waitTx("t6c", base + 2, 200);
    hpd = 1'b0;
    repeat (60) @(negedge refClock);
    chk("t6InFlightHigh", txHigh[base + 1], ACK_DELAY + 1);
    chk("t6NoNewWrite", txData.size(), base + 2);
    chk("t6IdleAfterLoss", {busy, configDone}, 2'b00);
    hpd = 1'b1;
    repeat (3) @(negedge refClock);
    waitFin("t6d", 2000);
    chk("t6AfterLossFirst", txData[base + 2], 24'h724110);
    chk("t6AfterLossCount", txData.size(), base + 14);
    chk("t6AfterLossDone", configDone, 1'b1);

    // asynchronous reset while i2cGo is high
    pulseStart();
    n = 0;
    while (!i2cGo && n < 20) begin
      @(negedge refClock);
      n++;
    end
    chkRange("t7GoSeen", n, 0, 19);
    reset = 1'b1;
    #1;
    chk("t7ResetMidOp", {i2cData, i2cGo, regIndex, busy, configDone, configError}, 32'h0);

    chk("dataStableWhileGo", stableErr, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
